// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA raster timing generator.
// Default geometry is 640x480@60 from a 50 MHz clock (pixel = 2 clk).
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Length of one full axis period (line in pixels, or frame in lines).
    function automatic int total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// Used once per axis; the vertical copy is enabled only on the horizontal wrap tick.
// region_nxt is the lookahead state so the parent can register decoded
// outputs that line up with cnt on the same edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT = DEF_H_ACTIVE,
    parameter int FP  = DEF_H_FP,
    parameter int SY  = DEF_H_SYNC,
    parameter int BP  = DEF_H_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] cnt,
    output region_t    region,
    output region_t    region_nxt,
    output logic       wrap
);

    localparam int         TOTAL    = total(ACT, FP, SY, BP);
    localparam logic [9:0] ACT_LAST = 10'(ACT - 1);
    localparam logic [9:0] FP_LAST  = 10'(ACT + FP - 1);
    localparam logic [9:0] SY_LAST  = 10'(ACT + FP + SY - 1);
    localparam logic [9:0] TOT_LAST = 10'(TOTAL - 1);

    logic [9:0] cnt_nxt;

    assign wrap = (cnt == TOT_LAST);

    // Next position and region; regions change on the tick at region end-1.
    always_comb begin
        cnt_nxt    = cnt;
        region_nxt = region;
        if (en) begin
            cnt_nxt = wrap ? 10'd0 : cnt + 10'd1;
            case (region)
                ACTIVE:  if (cnt == ACT_LAST) region_nxt = FRONT;
                FRONT:   if (cnt == FP_LAST)  region_nxt = SYNC;
                SYNC:    if (cnt == SY_LAST)  region_nxt = BACK;
                BACK:    if (wrap)            region_nxt = ACTIVE;
                default:                      region_nxt = ACTIVE;
            endcase
        end
    end

    // Position and region state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 10'd0;
            region <= ACTIVE;
        end else begin
            cnt    <= cnt_nxt;
            region <= region_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, x/y scan counters, registered sync/blank,
// frame_start pulse and DAC control pins.
// Optional: define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       sync_n,
    output logic       vga_clk,
    output logic       pix_tick,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    region_t          h_region;
    region_t          v_region;
    region_t          h_region_nxt;
    region_t          v_region_nxt;
    logic             unused_region;

    assign pix_tick   = (div_cnt == DIV_LAST);
    assign frame_wrap = pix_tick & h_wrap & v_wrap;
    assign sync_n     = 1'b0;

    // Current-state regions are only observed by the lookahead path.
    assign unused_region = ^{h_region, v_region};

    // Pixel clock divider; holds at 0 when every clk is a pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // DAC pixel clock: with no division the board clock is passed straight through.
    generate
        if (CLK_DIV == 1) begin : g_clk_pass
            assign vga_clk = clk;
        end else begin : g_clk_div
            assign vga_clk = (div_cnt >= DIV_W'(CLK_DIV / 2));
        end
    endgenerate

    vga_axis_counter #(
        .ACT(H_ACTIVE), .FP(H_FP), .SY(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(clk), .rst(rst), .en(pix_tick),
        .cnt(x), .region(h_region), .region_nxt(h_region_nxt), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACT(V_ACTIVE), .FP(V_FP), .SY(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(clk), .rst(rst), .en(pix_tick & h_wrap),
        .cnt(y), .region(v_region), .region_nxt(v_region_nxt), .wrap(v_wrap)
    );

    // Sync/blank registered from the lookahead regions so they change on the same edge as x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            blank_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (pix_tick) begin
                hsync   <= (h_region_nxt == SYNC) ? SYNC_ON : ~SYNC_ON;
                vsync   <= (v_region_nxt == SYNC) ? SYNC_ON : ~SYNC_ON;
                blank_n <= (h_region_nxt == ACTIVE) && (v_region_nxt == ACTIVE);
            end
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
